// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM states and parity constants for the serial parity-check path
package parity_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, HOLD} state_t;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  localparam int ERRCNT_W = 16;
endpackage

// File: rtl/parity_accum.sv
// parity_accum: running XOR accumulator with clear, load and enable
module parity_accum (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic en,
  input  logic d,
  output logic acc
);
  always_ff @(posedge clk)
    acc <= clr ? 1'b0 : load ? d : en ? acc ^ d : acc;
endmodule

// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl: frames serial data+parity bits into checked words; PARITY_ERRCNT_EN adds err_cnt/err_clr
module parity_frame_ctrl
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              datain,
  input  logic              bit_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] data_out,
  output logic              par_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
`ifdef PARITY_ERRCNT_EN
  input  logic              err_clr,
  output logic [ERRCNT_W-1:0] err_cnt,
`endif
  output logic              busy
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic POL = (ODD != 0) ? PAR_ODD : PAR_EVEN;
  state_t state;
  logic [DATA_W-1:0] sr;
  logic [CW-1:0] cnt;
  logic acc, sv, start, accept;
  assign sv = bit_valid & sof;
  assign accept = out_valid & out_ready;
  // a sof while holding a word only restarts if that word leaves the same cycle
  assign start = sv & (state != HOLD | out_ready);
  parity_accum u_acc (
    .clk (clk),
    .clr (rst),
    .load(start),
    .en  (bit_valid & ~sof & state == DATA),
    .d   (datain),
    .acc (acc)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      data_out <= '0;
      par_err <= 1'b0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
      busy <= 1'b0;
    end else if (start) begin
      sr <= {{(DATA_W-1){1'b0}}, datain};
      cnt <= CW'(1);
      state <= DATA;
      busy <= 1'b1;
      out_valid <= 1'b0;
    end else
      case (state)
        DATA: if (bit_valid) begin
          sr <= {sr[DATA_W-2:0], datain};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DATA_W - 1)) state <= PARITY;
        end
        PARITY: if (bit_valid) begin
          data_out <= sr;
          par_err <= acc ^ datain ^ POL;
          out_valid <= 1'b1;
          busy <= 1'b0;
          cnt <= '0;
          state <= HOLD;
        end
        HOLD: if (accept) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end else if (sv) overrun <= 1'b1;
        default: ;
      endcase
`ifdef PARITY_ERRCNT_EN
  always_ff @(posedge clk)
    if (rst | err_clr) err_cnt <= '0;
    else if (accept & par_err & ~&err_cnt) err_cnt <= err_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_parity_frame_ctrl.sv
// tb_parity_frame_ctrl: directed self-checking bench for parity_frame_ctrl (even and odd instances)
module tb_parity_frame_ctrl;
  logic clk = 0, rst = 1, datain = 0, bit_valid = 0, sof = 0, out_ready = 0;
  logic [7:0] d0, d1;
  logic pe0, pe1, ov0, ov1, ovr0, ovr1, bz0, bz1;
  int n_cmp = 0, n_err = 0, nacc = 0, base;
`ifdef PARITY_ERRCNT_EN
  logic err_clr = 0;
  logic [15:0] ec0, ec1;
`endif
  always #5 clk = ~clk;

  parity_frame_ctrl #(.DATA_W(8), .ODD(0)) u0 (
    .clk(clk), .rst(rst), .datain(datain), .bit_valid(bit_valid), .sof(sof),
    .data_out(d0), .par_err(pe0), .out_valid(ov0), .out_ready(out_ready), .overrun(ovr0),
`ifdef PARITY_ERRCNT_EN
    .err_clr(err_clr), .err_cnt(ec0),
`endif
    .busy(bz0));
  parity_frame_ctrl #(.DATA_W(8), .ODD(1)) u1 (
    .clk(clk), .rst(rst), .datain(datain), .bit_valid(bit_valid), .sof(sof),
    .data_out(d1), .par_err(pe1), .out_valid(ov1), .out_ready(out_ready), .overrun(ovr1),
`ifdef PARITY_ERRCNT_EN
    .err_clr(err_clr), .err_cnt(ec1),
`endif
    .busy(bz1));

  always @(posedge clk)
    if (rst) nacc <= 0;
    else if (ov0 & out_ready) nacc <= nacc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic b, input logic s, input int gap);
    datain = b; bit_valid = 1; sof = s;
    @(negedge clk);
    bit_valid = 0; sof = 0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] d, input logic p, input int gap);
    send(d[7], 1, gap);
    for (int i = 6; i >= 0; i--) send(d[i], 0, gap);
    send(p, 0, gap);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_data", d0, 0);
    chk("rst_valid", ov0, 0);
    chk("rst_perr", pe0, 0);
    chk("rst_ovr", ovr0, 0);
    chk("rst_busy", bz0, 0);
    rst = 0;
    out_ready = 1;
    send(1, 1, 0);
    chk("t1_busy_data", bz0, 1);
    for (int i = 6; i >= 0; i--) send(i == 5 || i == 4 || i == 1, 0, 0);
    chk("t1_busy_par", bz0, 1);
    send(0, 0, 0);
    chk("t1_valid", ov0, 1);
    chk("t1_data", d0, 8'hB2);
    chk("t1_perr", pe0, 0);
    chk("t1_busy_hold", bz0, 0);
    @(negedge clk);
    chk("t1_accepted", ov0, 0);
    chk("t1_one_word", nacc, 1);
    frame(8'hB2, 1, 0);
    chk("t2_data", d0, 8'hB2);
    chk("t2_perr", pe0, 1);
    @(negedge clk);
`ifdef PARITY_ERRCNT_EN
    chk("t2_errcnt", ec0, 1);
`endif
    frame(8'hFF, 1, 0);
    chk("t3_odd_data", d1, 8'hFF);
    chk("t3_odd_ok", pe1, 0);
    chk("t3_even_bad", pe0, 1);
    @(negedge clk);
    frame(8'hFF, 0, 0);
    chk("t3_odd_bad", pe1, 1);
    chk("t3_even_ok", pe0, 0);
    @(negedge clk);
`ifdef PARITY_ERRCNT_EN
    chk("t3_errcnt", ec0, 2);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("errclr", ec0, 0);
`endif
    out_ready = 0;
    frame(8'hB2, 0, 0);
    chk("t4_valid", ov0, 1);
    send(1, 1, 0);
    chk("t4_overrun", ovr0, 1);
    chk("t4_data_kept", d0, 8'hB2);
    chk("t4_still_valid", ov0, 1);
    chk("t4_not_busy", bz0, 0);
    out_ready = 1;
    @(negedge clk);
    chk("t4_accepted", ov0, 0);
    repeat (3) @(negedge clk);
    chk("t4_idle", bz0, 0);
    chk("t4_sticky", ovr0, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t4_ovr_cleared", ovr0, 0);
    send(1, 1, 0);
    send(0, 0, 0);
    send(1, 0, 0);
    frame(8'h5A, 0, 0);
    chk("t5_data", d0, 8'h5A);
    chk("t5_perr", pe0, 0);
    @(negedge clk);
    chk("t5_one_word", nacc, 1);
    out_ready = 0;
    send(0, 1, 1);
    send(1, 0, 2);
    send(1, 0, 3);
    frame(8'h5A, 0, 3);
    chk("t5g_valid", ov0, 1);
    chk("t5g_data", d0, 8'h5A);
    chk("t5g_perr", pe0, 0);
    out_ready = 1;
    @(negedge clk);
    chk("t5g_one_word", nacc, 2);
    out_ready = 0;
    frame(8'hB2, 0, 0);
    out_ready = 1;
    base = nacc;
    send(1, 1, 0);
    chk("acc_sof_valid", ov0, 0);
    chk("acc_sof_busy", bz0, 1);
    chk("acc_sof_no_ovr", ovr0, 0);
    chk("acc_sof_taken", nacc, base + 1);
    for (int i = 0; i < 7; i++) send(0, 0, 0);
    send(1, 0, 0);
    chk("acc_sof_data", d0, 8'h80);
    chk("acc_sof_perr", pe0, 0);
    @(negedge clk);
    send(1, 1, 0);
    for (int i = 0; i < 4; i++) send(1, 0, 0);
    chk("t6_busy", bz0, 1);
    rst = 1;
    @(negedge clk);
    chk("t6_data", d0, 0);
    chk("t6_valid", ov0, 0);
    chk("t6_perr", pe0, 0);
    chk("t6_busy_clr", bz0, 0);
    rst = 0;
    out_ready = 0;
    frame(8'hB2, 1, 0);
    chk("t6_after_data", d0, 8'hB2);
    chk("t6_after_perr", pe0, 1);
    chk("t6_after_valid", ov0, 1);
    out_ready = 1;
    @(negedge clk);
    chk("t6_after_accept", ov0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
